// File: rtl/button_ctrl_if.sv
// Button/CPU-side bundle for button_ctrl: raw buttons and game state in,
// debounced levels, pulses, difficulty and restart request out.
interface button_ctrl_if;
  logic        btn_l;
  logic        btn_c;
  logic        btn_r;
  logic        btn_u;
  logic        btn_d;
  logic [31:0] game_state;
  logic [31:0] difficulty;
  logic        diff_chg;
  logic [4:0]  btn_pulse;
  logic [4:0]  btn_level;
  logic        restart_req;

  modport master (
    output btn_l, btn_c, btn_r, btn_u, btn_d, game_state,
    input  difficulty, diff_chg, btn_pulse, btn_level, restart_req
  );

  modport slave (
    input  btn_l, btn_c, btn_r, btn_u, btn_d, game_state,
    output difficulty, diff_chg, btn_pulse, btn_level, restart_req
  );
endinterface

// File: rtl/button_ctrl.sv
// Five-button front end: per-button sync + debounce + rising-edge pulse,
// then the difficulty-select FSM and the restart handshake with the CPU.
module button_ctrl_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic anti_reset,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      pulse   <= level & ~level_q;
      // Counter clears at the terminal count, so it can never wrap.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] DIFF_DEFAULT    = 32'd2
) (
  input logic         clock,
  input logic         anti_reset,
  button_ctrl_if.slave bus
);
  localparam int NUM_BTN = 5;

  typedef enum logic {SELECT, LOCKED} state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pulse;

  assign raw = {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_c, bus.btn_l};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    button_ctrl_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clock      (clock),
      .anti_reset (anti_reset),
      .raw        (raw[i]),
      .level      (level[i]),
      .pulse      (pulse[i])
    );
  end

  state_t     state, state_nxt;
  logic [1:0] diff, diff_nxt;
  logic       chg, chg_nxt;
  logic       restart, restart_nxt;

  // Only the two low bits are stored; the upper difficulty bits are tied to 0.
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      state   <= SELECT;
      diff    <= DIFF_DEFAULT[1:0];
      chg     <= 1'b0;
      restart <= 1'b0;
    end else begin
      state   <= state_nxt;
      diff    <= diff_nxt;
      chg     <= chg_nxt;
      restart <= restart_nxt;
    end
  end

  always_comb begin
    state_nxt   = (bus.game_state == 32'd0) ? SELECT : LOCKED;
    diff_nxt    = diff;
    chg_nxt     = 1'b0;
    restart_nxt = restart;

    if (state == SELECT) begin
      if (pulse[0]) begin
        diff_nxt = 2'd1;
        chg_nxt  = 1'b1;
      end else if (pulse[1]) begin
        diff_nxt = 2'd2;
        chg_nxt  = 1'b1;
      end else if (pulse[2]) begin
        diff_nxt = 2'd3;
        chg_nxt  = 1'b1;
      end
    end

    // Held until the CPU returns to the menu; extra presses are absorbed.
    if (restart) begin
      if (bus.game_state == 32'd0) restart_nxt = 1'b0;
    end else if (pulse[3] && bus.game_state == 32'd2) begin
      restart_nxt = 1'b1;
    end
  end

  assign bus.difficulty  = {30'd0, diff};
  assign bus.diff_chg    = chg;
  assign bus.btn_pulse   = pulse;
  assign bus.btn_level   = level;
  assign bus.restart_req = restart;
endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with a 4-cycle debounce window.
module tb_button_ctrl;
  logic clock = 1'b0;
  logic anti_reset;
  int   vecs = 0;
  int   errs = 0;

  button_ctrl_if bus();

  button_ctrl #(.DEBOUNCE_CYCLES(4), .DIFF_DEFAULT(32'd2)) dut (
    .clock      (clock),
    .anti_reset (anti_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    bus.btn_l = m[0];
    bus.btn_c = m[1];
    bus.btn_r = m[2];
    bus.btn_u = m[3];
    bus.btn_d = m[4];
  endtask

  task automatic release_all();
    set_btns(5'b0);
    repeat (8) tick();
  endtask

  task automatic test_reset();
    anti_reset = 1'b0;
    bus.game_state = 32'd0;
    set_btns(5'b0);
    tick(); tick();
    vecs++; if (bus.difficulty !== 32'd2) begin errs++; $display("FAIL reset_diff got %0d want 2", bus.difficulty); end
    vecs++; if (bus.diff_chg !== 1'b0) begin errs++; $display("FAIL reset_chg got %b want 0", bus.diff_chg); end
    vecs++; if (bus.btn_pulse !== 5'b0) begin errs++; $display("FAIL reset_pulse got %b want 0", bus.btn_pulse); end
    vecs++; if (bus.btn_level !== 5'b0) begin errs++; $display("FAIL reset_level got %b want 0", bus.btn_level); end
    vecs++; if (bus.restart_req !== 1'b0) begin errs++; $display("FAIL reset_restart got %b want 0", bus.restart_req); end
    anti_reset = 1'b1;
    tick();
  endtask

  task automatic test_glitch();
    set_btns(5'b00100);
    repeat (3) tick();
    set_btns(5'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vecs++; if (bus.btn_level !== 5'b0) begin errs++; $display("FAIL glitch_level k=%0d got %b want 0", k, bus.btn_level); end
      vecs++; if (bus.btn_pulse !== 5'b0) begin errs++; $display("FAIL glitch_pulse k=%0d got %b want 0", k, bus.btn_pulse); end
      vecs++; if (bus.difficulty !== 32'd2) begin errs++; $display("FAIL glitch_diff k=%0d got %0d want 2", k, bus.difficulty); end
    end
  endtask

  task automatic test_press_l();
    bus.game_state = 32'd0;
    set_btns(5'b00001);
    for (int k = 1; k <= 9; k++) begin
      tick();
      vecs++; if (bus.btn_level[0] !== (k >= 6)) begin errs++; $display("FAIL l_level k=%0d got %b want %b", k, bus.btn_level[0], (k >= 6)); end
      vecs++; if (bus.btn_pulse !== ((k == 7) ? 5'b00001 : 5'b0)) begin errs++; $display("FAIL l_pulse k=%0d got %b", k, bus.btn_pulse); end
      vecs++; if (bus.difficulty !== ((k >= 8) ? 32'd1 : 32'd2)) begin errs++; $display("FAIL l_diff k=%0d got %0d", k, bus.difficulty); end
      vecs++; if (bus.diff_chg !== (k == 8)) begin errs++; $display("FAIL l_chg k=%0d got %b want %b", k, bus.diff_chg, (k == 8)); end
    end
    set_btns(5'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      vecs++; if (bus.btn_level[0] !== (k < 6)) begin errs++; $display("FAIL l_fall_level k=%0d got %b want %b", k, bus.btn_level[0], (k < 6)); end
      vecs++; if (bus.btn_pulse !== 5'b0) begin errs++; $display("FAIL l_fall_pulse k=%0d got %b want 0", k, bus.btn_pulse); end
    end
  endtask

  task automatic test_locked();
    bus.game_state = 32'd1;
    tick(); tick();
    set_btns(5'b10010);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vecs++; if (bus.btn_pulse !== ((k == 7) ? 5'b10010 : 5'b0)) begin errs++; $display("FAIL locked_pulse k=%0d got %b", k, bus.btn_pulse); end
      vecs++; if (bus.diff_chg !== 1'b0) begin errs++; $display("FAIL locked_chg k=%0d got %b want 0", k, bus.diff_chg); end
      vecs++; if (bus.difficulty !== 32'd1) begin errs++; $display("FAIL locked_diff k=%0d got %0d want 1", k, bus.difficulty); end
    end
    release_all();
  endtask

  task automatic test_restart();
    bus.game_state = 32'd1;
    set_btns(5'b01000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vecs++; if (bus.restart_req !== 1'b0) begin errs++; $display("FAIL restart_play k=%0d got %b want 0", k, bus.restart_req); end
    end
    release_all();
    bus.game_state = 32'd2;
    set_btns(5'b01000);
    for (int k = 1; k <= 9; k++) begin
      tick();
      vecs++; if (bus.restart_req !== (k >= 8)) begin errs++; $display("FAIL restart_set k=%0d got %b want %b", k, bus.restart_req, (k >= 8)); end
    end
    release_all();
    set_btns(5'b01000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vecs++; if (bus.btn_pulse !== ((k == 7) ? 5'b01000 : 5'b0)) begin errs++; $display("FAIL restart_u2_pulse k=%0d got %b", k, bus.btn_pulse); end
      vecs++; if (bus.restart_req !== 1'b1) begin errs++; $display("FAIL restart_hold k=%0d got %b want 1", k, bus.restart_req); end
      vecs++; if (bus.difficulty !== 32'd1) begin errs++; $display("FAIL restart_diff k=%0d got %0d want 1", k, bus.difficulty); end
    end
    release_all();
    bus.game_state = 32'd0;
    #1;
    vecs++; if (bus.restart_req !== 1'b1) begin errs++; $display("FAIL restart_pre_clear got %b want 1", bus.restart_req); end
    tick();
    vecs++; if (bus.restart_req !== 1'b0) begin errs++; $display("FAIL restart_clear got %b want 0", bus.restart_req); end
    tick();
  endtask

  task automatic test_press_r();
    for (int rep = 0; rep < 2; rep++) begin
      set_btns(5'b00100);
      for (int k = 1; k <= 9; k++) begin
        tick();
        vecs++; if (bus.difficulty !== ((k >= 8 || rep == 1) ? 32'd3 : 32'd1)) begin errs++; $display("FAIL r_diff rep=%0d k=%0d got %0d", rep, k, bus.difficulty); end
        vecs++; if (bus.diff_chg !== (k == 8)) begin errs++; $display("FAIL r_chg rep=%0d k=%0d got %b want %b", rep, k, bus.diff_chg, (k == 8)); end
      end
      release_all();
    end
  endtask

  task automatic test_reset_mid();
    bus.game_state = 32'd0;
    set_btns(5'b00010);
    repeat (4) tick();
    anti_reset = 1'b0;
    #1;
    vecs++; if (bus.difficulty !== 32'd2) begin errs++; $display("FAIL midrst_diff got %0d want 2", bus.difficulty); end
    vecs++; if (bus.btn_level !== 5'b0) begin errs++; $display("FAIL midrst_level got %b want 0", bus.btn_level); end
    vecs++; if (bus.btn_pulse !== 5'b0) begin errs++; $display("FAIL midrst_pulse got %b want 0", bus.btn_pulse); end
    tick(); tick();
    anti_reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      vecs++; if (bus.btn_level[1] !== (k >= 6)) begin errs++; $display("FAIL midrst_relevel k=%0d got %b want %b", k, bus.btn_level[1], (k >= 6)); end
      vecs++; if (bus.btn_pulse !== ((k == 7) ? 5'b00010 : 5'b0)) begin errs++; $display("FAIL midrst_repulse k=%0d got %b", k, bus.btn_pulse); end
      vecs++; if (bus.diff_chg !== (k == 8)) begin errs++; $display("FAIL midrst_chg k=%0d got %b want %b", k, bus.diff_chg, (k == 8)); end
      vecs++; if (bus.difficulty !== 32'd2) begin errs++; $display("FAIL midrst_rediff k=%0d got %0d want 2", k, bus.difficulty); end
    end
    release_all();
  endtask

  task automatic test_simultaneous();
    bus.game_state = 32'd0;
    set_btns(5'b00101);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vecs++; if (bus.btn_pulse !== ((k == 7) ? 5'b00101 : 5'b0)) begin errs++; $display("FAIL simul_pulse k=%0d got %b", k, bus.btn_pulse); end
      vecs++; if (bus.difficulty !== ((k >= 8) ? 32'd1 : 32'd2)) begin errs++; $display("FAIL simul_diff k=%0d got %0d", k, bus.difficulty); end
      vecs++; if (bus.diff_chg !== (k == 8)) begin errs++; $display("FAIL simul_chg k=%0d got %b want %b", k, bus.diff_chg, (k == 8)); end
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_l();
    test_locked();
    test_restart();
    test_press_r();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter DIFF_DEFAULT, default 2, meaning the difficulty value loaded at reset.
REQ-003 clock  input  1  50 MHz system clock; all state on rising edge.
REQ-004 anti_reset  input  1  asynchronous, active-low reset.
REQ-005 btn_l, btn_c, btn_r, btn_u, btn_d  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 game_state  input  32  CPU-owned game state: 0 = menu, 1 = playing, 2 = game over; other values are treated as playing.
REQ-007 difficulty  output  32  difficulty value driven to the CPU difficulty_in port.
REQ-008 diff_chg  output  1  single-cycle pulse on each difficulty update.
REQ-009 btn_pulse  output  5  single-cycle rising-edge pulses on debounced buttons, bit order {d,u,r,c,l} = [4:0].
REQ-010 btn_level  output  5  debounced levels, same bit order as btn_pulse.
REQ-011 restart_req  output  1  restart request to the CPU, held until acknowledged by game_state.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each button SHALL have its own debounce counter: it increments while the synchronized value differs from btn_level, and clears to 0 in any cycle where they are equal.
REQ-014 When a counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.
REQ-016 btn_pulse[i] SHALL be high for exactly one cycle, namely the cycle immediately after btn_level[i] rises.
REQ-017 Falling edges of btn_level SHALL NOT produce a pulse.
REQ-018 Total latency from a clean raw rising edge to btn_pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 clock edges.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change in btn_level and no pulse.
REQ-020 Difficulty FSM states:
- SELECT: entered when game_state == 0.
- LOCKED: entered when game_state != 0.
- The state register updates every cycle from game_state.
REQ-021 In SELECT, a pulse on l, c or r SHALL load difficulty with 1, 2 or 3 respectively on the next edge and assert diff_chg for that one cycle.
REQ-022 Simultaneous l/c/r pulses SHALL resolve by priority l > c > r.
REQ-023 In LOCKED, l/c/r pulses SHALL be ignored: difficulty holds and no diff_chg is produced.
REQ-024 A pulse selecting the value difficulty already holds SHALL still assert diff_chg.
REQ-025 difficulty[31:2] SHALL always be 0.
REQ-026 A btn_u pulse while game_state == 2 SHALL set restart_req on the next edge.
REQ-027 restart_req SHALL stay high until game_state == 0 is sampled, then clear on the following edge.
REQ-028 Further btn_u pulses while restart_req is high SHALL have no effect.
REQ-029 A btn_u pulse in any game_state other than 2 SHALL be ignored.
REQ-030 btn_d has no FSM function and SHALL appear only on btn_level and btn_pulse.

Reset
REQ-031 Assertion of anti_reset = 0 SHALL immediately, without waiting for a clock edge, force:
- difficulty = DIFF_DEFAULT
- diff_chg = 0, btn_pulse = 0, btn_level = 0, restart_req = 0
- all synchronizers and counters = 0
- FSM = SELECT
REQ-032 Reset asserted mid-debounce SHALL discard the partial count.
REQ-033 After reset release, a button already held high SHALL be accepted as a fresh press, with full latency and one pulse.
REQ-034 Deassertion of reset SHALL be treated as synchronous to clock; release-timing synchronization is the top level's responsibility.

Verification (DEBOUNCE_CYCLES = 4)
REQ-035 Reset, then game_state = 0, btn_l held high -> btn_level[0] rises 6 edges after the raw edge, btn_pulse[0] high 1 cycle, difficulty = 1, diff_chg high 1 cycle.
REQ-036 btn_r high for 3 cycles, then low -> no btn_level change, no pulse, difficulty stays 2.
REQ-037 game_state = 1, btn_c press -> btn_pulse[1] seen, difficulty unchanged, diff_chg never asserted.
REQ-038 btn_l and btn_r rise on the same cycle with game_state = 0 -> difficulty = 1, a single diff_chg pulse.
REQ-039 game_state = 2, btn_u press -> restart_req = 1; second press -> no change; game_state = 0 -> restart_req = 0 one edge later.
REQ-040 anti_reset pulsed low mid-debounce of btn_c while difficulty = 3 -> difficulty = 2 immediately, no pulse; held button re-debounces after release with full latency.
